// File: rtl/pi_seq_pkg.sv
// Shared definitions for the PI-integrator frame sequencer.
//   seq_state_e : sequencer FSM states
//   WORD_W      : operand / result word width
//   *_DEF       : default timing and size parameters
//   cnt_width() : width of a down-counter that must hold the largest load value
package pi_seq_pkg;

   localparam int WORD_W      = 32;
   localparam int N_CH_DEF    = 8;
   localparam int ADDR_W_DEF  = 4;
   localparam int LEAD_DEF    = 15;
   localparam int Y_OFS_DEF   = 0;
   localparam int TIMEOUT_DEF = 64;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LEAD    = 3'd1,
      ST_STREAM  = 3'd2,
      ST_WAIT_Y  = 3'd3,
      ST_CAPTURE = 3'd4,
      ST_DONE    = 3'd5
   } seq_state_e;

   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/seq_window_cnt.sv
// Enable-window generator: a start pulse opens an N_CH-cycle window whose
// first cycle is the start cycle itself, with an index 0..N_CH-1.
// Ports:
//   clk_i    in   clock
//   rst_i    in   synchronous reset, active-low
//   start_i  in   1-cycle start pulse (ignored while a window is open)
//   en_o     out  window enable
//   idx_o    out  index within window, 0 outside
module seq_window_cnt #(
   parameter int N_CH   = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   output logic              en_o,
   output logic [ADDR_W-1:0] idx_o
);

   logic              active_q, active_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   // Index 0 is served combinationally in the start cycle, so the register
   // only tracks indices 1..N_CH-1.
   always_comb begin
      active_d = active_q;
      cnt_d    = cnt_q;
      if (active_q) begin
         if (cnt_q == ADDR_W'(N_CH - 1)) begin
            active_d = 1'b0;
            cnt_d    = '0;
         end else begin
            cnt_d = cnt_q + ADDR_W'(1);
         end
      end else if (start_i && (N_CH > 1)) begin
         active_d = 1'b1;
         cnt_d    = ADDR_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         active_q <= active_d;
         cnt_q    <= cnt_d;
      end
   end

   assign en_o  = start_i | active_q;
   assign idx_o = active_q ? cnt_q : '0;

endmodule

// File: rtl/pi_integrator_frame_sequencer.sv
// Initiator side of the time-multiplexed PI-integrator handshake. Per frame it
// pops the previous x (done_read_x), streams N_CH operands from the source
// buffer behind an sta pulse, waits for done_sig and stores N_CH results.
// Ports:
//   clk_i, rst_i         clock, synchronous active-low reset
//   frame_start_i        request one frame
//   busy_o, frame_done_o frame in progress / end-of-frame pulse
//   timeout_err_o        sticky, cleared by next accepted frame
//   overrun_err_o        sticky, cleared only by reset
//   first_frame_o        high until the first frame after reset completes
//   src_rd_en_o/addr_o, src_data_i   source buffer read port (1-clk latency)
//   done_read_x_o, sta_o, x_o        integrator operand side
//   done_sig_i, y_i                  integrator result side
//   res_wr_en_o/addr_o/data_o        result buffer write port
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for frame_start
// ST_LEAD    | LEAD-clock gap between done_read_x and sta; source read starts
// ST_STREAM  | sta issued, x words streaming; timeout counter running
// ST_WAIT_Y  | waiting for done_sig or timeout
// ST_CAPTURE | Y_OFS delay, then N_CH results written
// ST_DONE    | frame_done pulse, back to idle
module pi_integrator_frame_sequencer
   import pi_seq_pkg::*;
#(
   parameter int N_CH    = N_CH_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int LEAD    = LEAD_DEF,
   parameter int Y_OFS   = Y_OFS_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              frame_start_i,
   output logic              busy_o,
   output logic              frame_done_o,
   output logic              timeout_err_o,
   output logic              overrun_err_o,
   output logic              first_frame_o,
   output logic              src_rd_en_o,
   output logic [ADDR_W-1:0] src_addr_o,
   input  logic [WORD_W-1:0] src_data_i,
   output logic              done_read_x_o,
   output logic              sta_o,
   output logic [WORD_W-1:0] x_o,
   input  logic              done_sig_i,
   input  logic [WORD_W-1:0] y_i,
   output logic              res_wr_en_o,
   output logic [ADDR_W-1:0] res_addr_o,
   output logic [WORD_W-1:0] res_data_o
);

   localparam int CNT_W = cnt_width(LEAD, TIMEOUT, Y_OFS);
   localparam logic [CNT_W-1:0] LEAD_LD    = CNT_W'(LEAD);
   localparam logic [CNT_W-1:0] TMO_LD     = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] OFS_LD     = CNT_W'(Y_OFS);
   // Counter value in the last x cycle (S+N_CH-1) of the stream.
   localparam logic [CNT_W-1:0] STREAM_END = CNT_W'(TIMEOUT - N_CH + 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TWO    = CNT_W'(2);

   seq_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              sta_q, sta_d;
   logic              drx_q, drx_d;
   logic              accept, tmo_set;
   logic              rd_start, cap_start;
   logic              rd_en, cap_en;
   logic [ADDR_W-1:0] rd_idx, cap_idx;
   logic              rd_vld_q;
   logic [WORD_W-1:0] x_q;
   logic              res_wr_en_q;
   logic [ADDR_W-1:0] res_addr_q;
   logic [WORD_W-1:0] res_data_q;
   logic              timeout_err_q, overrun_err_q, first_frame_q;

   seq_window_cnt #(.N_CH(N_CH), .ADDR_W(ADDR_W)) u_rd_win (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (rd_start),
      .en_o    (rd_en),
      .idx_o   (rd_idx)
   );

   seq_window_cnt #(.N_CH(N_CH), .ADDR_W(ADDR_W)) u_cap_win (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (cap_start),
      .en_o    (cap_en),
      .idx_o   (cap_idx)
   );

   // One down-counter serves as lead timer, timeout timer and Y_OFS delay.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sta_d     = 1'b0;
      drx_d     = 1'b0;
      accept    = 1'b0;
      tmo_set   = 1'b0;
      rd_start  = 1'b0;
      cap_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (frame_start_i) begin
               accept  = 1'b1;
               drx_d   = ~first_frame_q;  // integrator x FIFO is empty on the first frame
               cnt_d   = LEAD_LD;
               state_d = ST_LEAD;
            end
         end
         ST_LEAD: begin
            cnt_d = cnt_q - CNT_ONE;
            // Source read leads sta by 2: one clk RAM latency, one clk x register.
            if (cnt_q == CNT_TWO) rd_start = 1'b1;
            if (cnt_q == CNT_ONE) begin
               sta_d   = 1'b1;
               cnt_d   = TMO_LD;
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == STREAM_END) state_d = ST_WAIT_Y;
         end
         ST_WAIT_Y: begin
            cnt_d = cnt_q - CNT_ONE;
            if (done_sig_i) begin
               cnt_d   = OFS_LD;
               state_d = ST_CAPTURE;
               if (Y_OFS == 0) cap_start = 1'b1;
            end else if (cnt_q == CNT_ONE) begin
               tmo_set = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_CAPTURE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) cap_start = 1'b1;
            end
            if (res_wr_en_q && (res_addr_q == ADDR_W'(N_CH - 1))) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         sta_q         <= 1'b0;
         drx_q         <= 1'b0;
         rd_vld_q      <= 1'b0;
         x_q           <= '0;
         res_wr_en_q   <= 1'b0;
         res_addr_q    <= '0;
         res_data_q    <= '0;
         timeout_err_q <= 1'b0;
         overrun_err_q <= 1'b0;
         first_frame_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sta_q       <= sta_d;
         drx_q       <= drx_d;
         rd_vld_q    <= rd_en;
         x_q         <= rd_vld_q ? src_data_i : '0;
         res_wr_en_q <= cap_en;
         res_addr_q  <= cap_en ? cap_idx : '0;
         res_data_q  <= cap_en ? y_i : '0;
         if (accept)
            timeout_err_q <= 1'b0;
         else if (tmo_set)
            timeout_err_q <= 1'b1;
         // The DONE cycle counts as busy for overrun purposes.
         if (frame_start_i && (state_q != ST_IDLE)) overrun_err_q <= 1'b1;
         if (state_q == ST_DONE) first_frame_q <= 1'b0;
      end
   end

   assign busy_o        = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign frame_done_o  = (state_q == ST_DONE);
   assign timeout_err_o = timeout_err_q;
   assign overrun_err_o = overrun_err_q;
   assign first_frame_o = first_frame_q;
   assign src_rd_en_o   = rd_en;
   assign src_addr_o    = rd_idx;
   assign done_read_x_o = drx_q;
   assign sta_o         = sta_q;
   assign x_o           = x_q;
   assign res_wr_en_o   = res_wr_en_q;
   assign res_addr_o    = res_addr_q;
   assign res_data_o    = res_data_q;

endmodule

// File: tb/tb_pi_integrator_frame_sequencer.sv
module tb_pi_integrator_frame_sequencer;

   localparam int N_CH    = 8;
   localparam int ADDR_W  = 4;
   localparam int LEAD    = 15;
   localparam int Y_OFS   = 0;
   localparam int TIMEOUT = 64;
   localparam int AT_DONE = 999;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b0;
   logic              frame_start_i = 1'b0;
   logic              done_sig_i = 1'b0;
   logic [31:0]       src_data_i = '0;
   logic [31:0]       y_i = '0;
   logic              busy_o, frame_done_o, timeout_err_o, overrun_err_o, first_frame_o;
   logic              src_rd_en_o, done_read_x_o, sta_o, res_wr_en_o;
   logic [ADDR_W-1:0] src_addr_o, res_addr_o;
   logic [31:0]       x_o, res_data_o;

   int vectors = 0;
   int miscompares = 0;
   bit g_first = 1'b1;
   bit g_tmo = 1'b0;
   bit g_ovr = 1'b0;

   always #5 clk_i = ~clk_i;

   pi_integrator_frame_sequencer #(
      .N_CH(N_CH), .ADDR_W(ADDR_W), .LEAD(LEAD), .Y_OFS(Y_OFS), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .frame_start_i (frame_start_i),
      .busy_o        (busy_o),
      .frame_done_o  (frame_done_o),
      .timeout_err_o (timeout_err_o),
      .overrun_err_o (overrun_err_o),
      .first_frame_o (first_frame_o),
      .src_rd_en_o   (src_rd_en_o),
      .src_addr_o    (src_addr_o),
      .src_data_i    (src_data_i),
      .done_read_x_o (done_read_x_o),
      .sta_o         (sta_o),
      .x_o           (x_o),
      .done_sig_i    (done_sig_i),
      .y_i           (y_i),
      .res_wr_en_o   (res_wr_en_o),
      .res_addr_o    (res_addr_o),
      .res_data_o    (res_data_o)
   );

   task automatic check(input string tag, input int r, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s r=%0d observed=%h expected=%h", tag, r, obs, exp);
      end
   endtask

   function automatic logic [31:0] ctl_obs();
      return {23'b0, busy_o, frame_done_o, timeout_err_o, overrun_err_o, first_frame_o,
              src_rd_en_o, done_read_x_o, sta_o, res_wr_en_o};
   endfunction

   // Quiet/reset-state check: everything low except first_frame.
   task automatic check_reset_state(input string tag, input int r);
      check({tag, "_ctl"}, r, ctl_obs(), 32'h0000_0010);
      check({tag, "_x"}, r, x_o, 32'h0);
      check({tag, "_rdata"}, r, res_data_o, 32'h0);
      check({tag, "_addrs"}, r, {24'b0, src_addr_o, res_addr_o}, 32'h0);
   endtask

   // One frame, cycle r relative to frame_start (r=0). The expected timeline
   // comes straight from the frame rules: sta at S=1+LEAD, reads S-2..S+N-3,
   // x on S..S+N-1, writes after D+Y_OFS, done at end of capture or S+TIMEOUT.
   task automatic run_frame(input int d_off, input int ovr_in, input int rst_off,
                            input bit noise, input bit fixed_src);
      logic [31:0] fl [8];
      logic [31:0] src [N_CH];
      logic [31:0] yv [N_CH];
      int S, D, E, ovr_r, rst_r, last;
      bit to;
      logic e_busy, e_done, e_tmo, e_ovr, e_first, e_rd, e_drx, e_sta, e_wr;
      logic [31:0] e_x, e_rdata, e_saddr, e_raddr;
      fl = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
             32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
      for (int k = 0; k < N_CH; k++) begin
         src[k] = fixed_src ? fl[k] : $urandom;
         yv[k]  = $urandom;
      end
      S  = 1 + LEAD;
      to = (d_off < 0);
      D  = to ? -1000 : S + d_off;
      E  = to ? S + TIMEOUT : D + Y_OFS + N_CH + 1;
      ovr_r = (ovr_in == AT_DONE) ? E : ovr_in;
      rst_r = (rst_off < 0) ? -1 : S + rst_off;
      last  = (rst_r >= 0) ? rst_r + 2 : E + 1;
      e_ovr = g_ovr;
      for (int r = 0; r <= last; r++) begin
         frame_start_i = (r == 0) || (r == ovr_r);
         done_sig_i    = (r == D) || (noise && ((r == 3) || (r == S + 2) || (r == D + 3)));
         rst_i         = (r != rst_r);
         if (r >= S - 1 && r <= S + N_CH - 2) src_data_i = src[r - S + 1];
         else src_data_i = $urandom;
         if (!to && r >= D + Y_OFS && r < D + Y_OFS + N_CH) y_i = yv[r - D - Y_OFS];
         else y_i = $urandom;
         @(negedge clk_i);
         if (rst_r >= 0 && r > rst_r) begin
            check_reset_state("midrst", r);
         end else begin
            e_busy  = (r >= 1) && (r < E);
            e_done  = (r == E);
            e_tmo   = (r == 0) ? g_tmo : (to && r >= E);
            e_ovr   = g_ovr || (ovr_r >= 0 && r > ovr_r);
            e_first = (r <= E) ? g_first : 1'b0;
            e_rd    = (r >= S - 2) && (r <= S + N_CH - 3);
            e_saddr = e_rd ? 32'(r - S + 2) : 32'h0;
            e_drx   = (r == 1) && !g_first;
            e_sta   = (r == S);
            e_x     = 32'h0;
            if (r >= S && r < S + N_CH) e_x = src[r - S];
            e_wr    = !to && (r >= D + Y_OFS + 1) && (r <= D + Y_OFS + N_CH);
            e_raddr = 32'h0;
            e_rdata = 32'h0;
            if (e_wr) begin
               e_raddr = 32'(r - D - Y_OFS - 1);
               e_rdata = yv[r - D - Y_OFS - 1];
            end
            check("ctl", r, ctl_obs(), {23'b0, e_busy, e_done, e_tmo, e_ovr, e_first,
                                        e_rd, e_drx, e_sta, e_wr});
            check("src_addr", r, 32'(src_addr_o), e_saddr);
            check("x", r, x_o, e_x);
            check("res_addr", r, 32'(res_addr_o), e_raddr);
            check("res_data", r, res_data_o, e_rdata);
         end
         @(posedge clk_i);
         #1;
      end
      frame_start_i = 1'b0;
      done_sig_i    = 1'b0;
      rst_i         = 1'b1;
      if (rst_r >= 0) begin
         g_first = 1'b1;
         g_tmo   = 1'b0;
         g_ovr   = 1'b0;
      end else begin
         g_first = 1'b0;
         g_tmo   = to;
         g_ovr   = e_ovr;
      end
   endtask

   initial begin
      // T1: reset held 3 clocks, with a frame request that must be ignored
      rst_i = 1'b0;
      frame_start_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check_reset_state("reset", i);
      end
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      frame_start_i = 1'b0;
      @(posedge clk_i);
      #1;
      // T2: first frame, src[k]=k+1.0, done_sig at S+30
      run_frame(30, -1, -1, 1'b0, 1'b1);
      // T3: second frame, done_read_x expected, stray done_sig pulses ignored
      run_frame(int'($urandom_range(TIMEOUT - 1, N_CH)), -1, -1, 1'b1, 1'b0);
      // done_sig boundaries: earliest WAIT_Y cycle and last cycle before timeout
      run_frame(N_CH, -1, -1, 1'b0, 1'b0);
      run_frame(TIMEOUT - 1, -1, -1, 1'b1, 1'b0);
      // T4: timeout, then the next frame clears timeout_err
      run_frame(-1, -1, -1, 1'b0, 1'b0);
      // T5: overrun during LEAD, then frame_start in the DONE cycle
      run_frame(int'($urandom_range(TIMEOUT - 1, N_CH)), 5, -1, 1'b0, 1'b0);
      run_frame(int'($urandom_range(TIMEOUT - 1, N_CH)), AT_DONE, -1, 1'b1, 1'b0);
      // T6: reset at S+3, then a fresh first frame
      run_frame(30, -1, 3, 1'b0, 1'b0);
      run_frame(30, -1, -1, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++)
         run_frame(int'($urandom_range(TIMEOUT - 1, N_CH)), -1, -1, 1'b1, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
